// File: rtl/fir_tdm_controller.sv
// Time-multiplexed 8-tap FIR sequencer: circular sample history, one shared signed MAC
// walking the taps, a config-writable coefficient bank and valid/ready ports on both sides.
module fir_tdm_controller #(
  parameter int unsigned TAPS = 8,
  parameter int unsigned DW   = 8,
  parameter int unsigned CW   = 8,
  parameter int unsigned OW   = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DW-1:0]            s_data,
  input  logic                     flush,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [CW-1:0]            coef_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [OW-1:0]            m_data,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(TAPS);
  localparam int unsigned PW = DW + CW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Team default impulse response, tap 0 pairs with the newest sample.
  function automatic logic [CW-1:0] default_coef(input int k);
    case (k)
      0:       return CW'(2);
      1:       return CW'(4);
      2:       return CW'(6);
      3:       return CW'(8);
      4:       return CW'(6);
      5:       return CW'(4);
      6:       return CW'(2);
      7:       return CW'(1);
      default: return '0;
    endcase
  endfunction

  state_e state_q, state_d;

  logic [DW-1:0] hist_q [TAPS];
  logic [DW-1:0] hist_d [TAPS];
  logic [CW-1:0] coef_q [TAPS];
  logic [CW-1:0] coef_d [TAPS];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] newest_q, newest_d;
  logic [AW-1:0] k_q, k_d;
  logic [OW-1:0] acc_q, acc_d;
  logic [OW-1:0] m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;

  logic          accept_c;
  logic          flush_c;
  logic          coef_wr_c;
  logic          mac_c;
  logic          last_tap_c;
  logic          drain_c;

  logic [AW-1:0]        rd_idx_c;
  logic signed [PW-1:0] prod_c;
  logic [OW-1:0]        prod_ext_c;
  logic [OW-1:0]        acc_sum_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c)   state_d = ST_MAC;
      ST_MAC:  if (last_tap_c) state_d = ST_OUT;
      ST_OUT:  if (drain_c)    state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Output / control decode; flush blocks acceptance in the same cycle
  always_comb begin
    s_ready    = 1'b0;
    busy       = 1'b1;
    accept_c   = 1'b0;
    flush_c    = 1'b0;
    coef_wr_c  = 1'b0;
    mac_c      = 1'b0;
    last_tap_c = 1'b0;
    drain_c    = 1'b0;
    busy       = (state_q != ST_IDLE);
    s_ready    = (state_q == ST_IDLE) && !flush;
    accept_c   = s_ready && s_valid;
    flush_c    = (state_q == ST_IDLE) && flush;
    coef_wr_c  = (state_q == ST_IDLE) && coef_we;
    mac_c      = (state_q == ST_MAC);
    last_tap_c = mac_c && (k_q == AW'(TAPS - 1));
    drain_c    = (state_q == ST_OUT) && m_valid_q && m_ready;
  end

  // Shared multiplier: newest sample minus k, wrapping around the circular history
  always_comb begin
    rd_idx_c   = newest_q - k_q;
    prod_c     = $signed(hist_q[rd_idx_c]) * $signed(coef_q[k_q]);
    prod_ext_c = {{(OW - PW){prod_c[PW-1]}}, prod_c};
    acc_sum_c  = acc_q + prod_ext_c;
  end

  // Datapath next-state; a coefficient write lands before the accepted sample's MAC
  always_comb begin
    hist_d    = hist_q;
    coef_d    = coef_q;
    wr_ptr_d  = wr_ptr_q;
    newest_d  = newest_q;
    k_d       = k_q;
    acc_d     = acc_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;

    if (coef_wr_c) begin
      coef_d[coef_addr] = coef_data;
    end

    if (flush_c) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        hist_d[i] = '0;
      end
      wr_ptr_d = '0;
    end

    if (accept_c) begin
      hist_d[wr_ptr_q] = s_data;
      newest_d         = wr_ptr_q;
      wr_ptr_d         = wr_ptr_q + AW'(1);
      acc_d            = '0;
      k_d              = '0;
    end

    if (mac_c) begin
      acc_d = acc_sum_c;
      k_d   = k_q + AW'(1);
      if (last_tap_c) begin
        m_data_d  = acc_sum_c;
        m_valid_d = 1'b1;
      end
    end

    if (drain_c) begin
      m_valid_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= default_coef(i);
      end
      wr_ptr_q  <= '0;
      newest_q  <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      coef_q    <= coef_d;
      wr_ptr_q  <= wr_ptr_d;
      newest_q  <= newest_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

endmodule

// File: tb/tb_fir_tdm_controller.sv
// Self-checking bench for fir_tdm_controller: a sample-list FIR model checked every cycle,
// plus directed literal expectations and a randomized transaction phase.
module tb_fir_tdm_controller;

  localparam int TAPS = 8;
  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int OW   = 20;
  localparam int AW   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          flush = 1'b0;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [CW-1:0] coef_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [OW-1:0] m_data;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  fir_tdm_controller #(.TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy)
  );

  // Model: recent[0] is the newest sample; phase 0=idle, 1=computing, 2=result held
  int mdl_phase;
  int mdl_cnt;
  int mdl_res;
  int mdl_coef   [TAPS];
  int mdl_recent [TAPS];

  function automatic int def_coef(input int k);
    case (k)
      0: return 2;
      1: return 4;
      2: return 6;
      3: return 8;
      4: return 6;
      5: return 4;
      6: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int fir_out(input int s, input logic we, input logic [AW-1:0] a, input int cd);
    int sum;
    int c;
    int x;
    sum = 0;
    for (int k = 0; k < TAPS; k++) begin
      c = (we && (int'(a) == k)) ? cd : mdl_coef[k];
      x = (k == 0) ? s : mdl_recent[k-1];
      sum += c * x;
    end
    return sum;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_phase <= 0;
      mdl_cnt   <= 0;
      mdl_res   <= 0;
      for (int i = 0; i < TAPS; i++) begin
        mdl_coef[i]   <= def_coef(i);
        mdl_recent[i] <= 0;
      end
    end else begin
      case (mdl_phase)
        0: begin
          if (coef_we) mdl_coef[coef_addr] <= int'($signed(coef_data));
          if (flush) begin
            for (int i = 0; i < TAPS; i++) mdl_recent[i] <= 0;
          end else if (s_valid) begin
            for (int i = 1; i < TAPS; i++) mdl_recent[i] <= mdl_recent[i-1];
            mdl_recent[0] <= int'($signed(s_data));
            mdl_res   <= fir_out(int'($signed(s_data)), coef_we, coef_addr, int'($signed(coef_data)));
            mdl_cnt   <= TAPS;
            mdl_phase <= 1;
          end
        end
        1: begin
          mdl_cnt <= mdl_cnt - 1;
          if (mdl_cnt == 1) mdl_phase <= 2;
        end
        default: if (m_ready) mdl_phase <= 0;
      endcase
    end
  end

  task automatic cmp1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmpw(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmpi(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp1("m_valid", m_valid, mdl_phase == 2);
      cmp1("busy", busy, mdl_phase != 0);
      cmp1("s_ready", s_ready, (mdl_phase == 0) && !flush);
      if (mdl_phase == 2) cmpw("m_data", m_data, OW'(mdl_res));
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; s_valid = 1'b0; flush = 1'b0; coef_we = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic timeout(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timeout waiting at %0t", nm, $time);
  endtask

  // One transaction: present sample (optionally with a coefficient write), wait for the
  // result, stall m_ready for 'stall' cycles, then drain.
  task automatic xfer(input logic [DW-1:0] d, input logic we, input logic [AW-1:0] a,
                      input logic [CW-1:0] cd, input int stall,
                      output logic [OW-1:0] got, output int lat);
    int w;
    got = '0;
    lat = -1;
    s_valid = 1'b1; s_data = d; coef_we = we; coef_addr = a; coef_data = cd;
    m_ready = (stall == 0);
    w = 0;
    do begin @(negedge clk); w++; end while (!s_ready && w < 50);
    if (!s_ready) begin
      timeout("accept");
      s_valid = 1'b0; coef_we = 1'b0; m_ready = 1'b1;
      return;
    end
    @(posedge clk); #1;
    s_valid = 1'b0; coef_we = 1'b0;
    lat = 0;
    do begin @(posedge clk); lat++; #1; end while (!m_valid && lat < 50);
    if (!m_valid) begin
      timeout("result");
      m_ready = 1'b1;
      return;
    end
    got = m_data;
    repeat (stall) begin @(posedge clk); #1; end
    m_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [OW-1:0] exp, input string nm);
    logic [OW-1:0] got;
    int lat;
    xfer(d, 1'b0, '0, '0, 0, got, lat);
    cmpw(nm, got, exp);
    cmpi({nm, " latency"}, lat, TAPS);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    do begin @(posedge clk); w++; #1; end while (busy && w < 50);
    if (busy) timeout("idle");
  endtask

  task automatic do_flush();
    flush = 1'b1; s_valid = 1'b1; s_data = 8'h33;
    repeat (2) begin @(posedge clk); #1; end
    cmp1("flush blocks accept", busy, 1'b0);
    flush = 1'b0; s_valid = 1'b0;
  endtask

  initial begin
    logic [OW-1:0] got;
    int lat;
    int w;
    logic [OW-1:0] imp_exp  [9];
    logic [OW-1:0] step_exp [9];
    imp_exp  = '{20'd2, 20'd4, 20'd6, 20'd8, 20'd6, 20'd4, 20'd2, 20'd1, 20'd0};
    step_exp = '{20'd20, 20'd60, 20'd120, 20'd200, 20'd260, 20'd300, 20'd320, 20'd330, 20'd330};

    // Power-on reset and reset values
    #1 rst = 1'b1;
    #2;
    cmp1("reset s_ready", s_ready, 1'b1);
    cmp1("reset m_valid", m_valid, 1'b0);
    cmpw("reset m_data", m_data, '0);
    cmp1("reset busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Impulse response
    for (int i = 0; i < 9; i++) send((i == 0) ? 8'd1 : 8'd0, imp_exp[i], "impulse");

    // Step response
    do_reset();
    for (int i = 0; i < 9; i++) send(8'd10, step_exp[i], "step");

    // Backpressure with the source holding the next sample
    do_reset();
    m_ready = 1'b0; s_valid = 1'b1; s_data = 8'd3;
    @(posedge clk); #1;
    s_data = 8'd7;
    w = 0;
    do begin @(posedge clk); w++; #1; end while (!m_valid && w < 50);
    if (!m_valid) timeout("bp result");
    repeat (5) begin
      cmpw("bp m_data", m_data, 20'd6);
      cmp1("bp s_ready", s_ready, 1'b0);
      cmp1("bp busy", busy, 1'b1);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    cmp1("bp idle gap", busy, 1'b0);
    @(posedge clk); #1;
    cmp1("bp next accept", busy, 1'b1);
    s_valid = 1'b0;
    w = 0;
    while (!m_valid && w < 50) begin @(posedge clk); w++; #1; end
    cmpw("bp second", m_data, 20'd26);
    wait_idle();

    // Coefficient write while busy is ignored; IDLE write applies to same-cycle sample
    do_reset();
    s_valid = 1'b1; s_data = 8'd0;
    @(posedge clk); #1;
    s_valid = 1'b0; coef_we = 1'b1; coef_addr = 3'd1; coef_data = 8'h7F;
    repeat (3) begin @(posedge clk); #1; end
    coef_we = 1'b0;
    wait_idle();
    xfer(8'd5, 1'b1, 3'd0, 8'hFF, 0, got, lat);
    cmpw("coef0 = -1", got, 20'hFFFFB);
    send(8'd0, 20'd20, "busy write ignored");

    // Negative full scale, then flush
    do_reset();
    for (int i = 0; i < 8; i++) begin
      xfer(8'h80, 1'b0, '0, '0, 0, got, lat);
    end
    send(8'h80, 20'hFEF80, "neg full scale");
    do_flush();
    send(8'h80, 20'hFFF00, "after flush");

    // Reset during MAC
    do_reset();
    send(8'd1, 20'd2, "pre-reset");
    s_valid = 1'b1; s_data = 8'd9;
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    cmp1("mid-reset m_valid", m_valid, 1'b0);
    cmp1("mid-reset s_ready", s_ready, 1'b1);
    cmp1("mid-reset busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(8'd1, 20'd2, "post-reset tap0");
    send(8'd0, 20'd4, "post-reset tap1");
    send(8'd0, 20'd6, "post-reset tap2");

    // Randomized transactions against the model
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_flush();
      end else begin
        xfer(DW'($urandom), ($urandom_range(0, 3) == 0), AW'($urandom), CW'($urandom),
             int'($urandom_range(0, 3)), got, lat);
        cmpi("random latency", lat, TAPS);
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_tdm_controller.md
Name: fir_tdm_controller

Overview:
Time-multiplexed sequencer for the team's 8-tap FIR datapath. It accepts one input sample per valid/ready handshake and holds it in a circular sample history. One shared signed multiplier-accumulator then walks all taps over TAPS cycles, and the 20-bit result is presented on a valid/ready output port. Coefficients are held in a register bank writable through a simple config port. It sits between the ADC-side sample source and the downstream output consumer.

Parameters:
TAPS, 8, number of taps; power of two; sets history depth and MAC cycle count
DW, 8, input sample width, signed
CW, 8, coefficient width, signed
OW, 20, accumulator and output width, signed

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
s_valid  in  1  input sample valid
s_ready  out  1  controller can accept a sample
s_data  in  DW  signed input sample
flush  in  1  clear sample history (honoured in IDLE only)
coef_we  in  1  coefficient write strobe
coef_addr  in  log2(TAPS)  coefficient index k
coef_data  in  CW  signed coefficient value
m_valid  out  1  output result valid
m_ready  in  1  downstream accepts result
m_data  out  OW  signed filtered output
busy  out  1  high when state is not IDLE

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values:
  - state=IDLE; s_ready=1; m_valid=0; m_data=0; busy=0.
  - Accumulator=0, tap counter=0, wr_ptr=0.
  - All history entries=0.
  - Coefficients = 2,4,6,8,6,4,2,1 for k=0..7 (team default response).
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - s_ready = !flush.
  - flush=1: zero all history entries and wr_ptr; the sample is not accepted.
  - s_valid & s_ready: write s_data to hist[wr_ptr], newest=wr_ptr, wr_ptr increments mod TAPS, accumulator=0, k=0, go to MAC.
- MAC:
  - Each cycle: acc += hist[(newest-k) mod TAPS] * coef[k]; k increments.
  - Tap k=0 pairs with the newest sample.
  - After the k=TAPS-1 accumulation: m_data=final acc, m_valid=1, go to OUT.
  - Total TAPS cycles in MAC.
- OUT:
  - m_valid held high; m_data held stable until m_ready=1.
  - On m_valid & m_ready: m_valid=0, go to IDLE.
- Latency: m_valid rises after the TAPS-th rising edge following the accepting edge (8 edges for TAPS=8).
- Throughput: at most one sample per TAPS+2 cycles, since one IDLE cycle is mandatory between results.
- s_ready=0 in MAC and OUT. s_valid there is ignored; the source must hold it.
- Arithmetic:
  - Each product is DW×CW signed (16 bits), sign-extended to OW.
  - Accumulation wraps modulo 2^OW; no saturation.
  - The default coefficients cannot overflow with 8-bit input.
- Coefficient writes:
  - Honoured only in IDLE; silently ignored in MAC and OUT.
  - coef_we together with an accepted sample in the same IDLE cycle: the write lands first, and the MAC for that sample uses the new value.
- flush together with s_valid in IDLE: flush wins and the sample is not accepted (s_ready=0).
- Reset mid-operation: any in-flight result is discarded, all state returns to reset values, m_valid drops immediately.
- busy = (state != IDLE).

Test Plan:
- Impulse: after reset, feed 1 then eight 0s, draining each result with m_ready=1 -> m_data = 2,4,6,8,6,4,2,1,0; each m_valid 8 edges after its accept.
- Step: feed nine samples of 10 -> m_data = 20,60,120,200,260,300,320,330,330.
- Backpressure: m_ready=0 for 5 cycles in OUT, s_valid held high -> m_data stable, s_ready=0, busy=1, no extra accept; the next accept happens only after the m_ready handshake plus one IDLE cycle.
- Coefficient write while busy is ignored; in IDLE write coef[0]=-1 (8'hFF) with zero history, then feed 5 -> m_data = -5.
- Negative full scale: steady stream of -128 with default coefficients -> settles to -4224 (20'hFEF80); flush, then feed -128 -> -256.
- Reset in MAC (assert rst at 4th MAC cycle) -> m_valid=0 at once, s_ready=1; next impulse reproduces 2,4,6,... from zero history.
